// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480@60 Hz timing constants, the 12-bit colour type and the
// colour-bar lookup used by the optional test pattern (VGA_TEST_PATTERN_EN).
// The renderer imports X_MAX/Y_MAX from here so both sides agree on the
// visible area.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // Pixel clock divider default: 100 MHz system clock -> 25 MHz pixel rate.
    localparam int CLK_DIV_DEFAULT = 4;

    // Horizontal timing, in pixels.
    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    // Vertical timing, in lines.
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    // Derived line/frame lengths and sync windows (inclusive bounds).
    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;  // 800
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;  // 525
    localparam int HS_START = H_DISPLAY + H_FRONT;                    // 656
    localparam int HS_END   = HS_START + H_SYNC - 1;                  // 751
    localparam int VS_START = V_DISPLAY + V_FRONT;                    // 490
    localparam int VS_END   = VS_START + V_SYNC - 1;                  // 491

    // Last visible coordinate, for the renderer.
    localparam int X_MAX = H_DISPLAY - 1;  // 639
    localparam int Y_MAX = V_DISPLAY - 1;  // 479

    // Counter width: both totals must fit in 10 bits.
    localparam int CNT_W = 10;

    // Colour depth: 4 bits each of R, G, B.
    localparam int RGB_W = 12;
    typedef logic [RGB_W-1:0] rgb_t;

    // Width of one test-pattern colour bar, in pixels.
    localparam int BAR_W = 80;

    // Colour for each of the eight vertical test bars, left to right.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t colour;
        case (idx)
            3'd0:    colour = 12'h000;
            3'd1:    colour = 12'hF00;
            3'd2:    colour = 12'h0F0;
            3'd3:    colour = 12'h00F;
            3'd4:    colour = 12'hFF0;
            3'd5:    colour = 12'h0FF;
            3'd6:    colour = 12'hF0F;
            default: colour = 12'hFFF;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// ---------------------------------------------------------------------------
// vga_pixel_tick
// Free-running CLK_DIV divider. p_tick is a registered one-clock pulse that
// fires when the divider wraps, so the first pulse appears CLK_DIV clocks
// after reset is released and then every CLK_DIV clocks. CLK_DIV must be 2
// or greater.
// ---------------------------------------------------------------------------
module vga_pixel_tick
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int                DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_p_tick;
    logic             w_div_wrap;

    assign w_div_wrap = (r_div_cnt == DIV_LAST);

    // Divider counts 0..CLK_DIV-1 and wraps; never stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Register the wrap so the pulse is glitch-free and exactly one clock wide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p_tick <= 1'b0;
        end else begin
            r_p_tick <= w_div_wrap;
        end
    end

    assign p_tick = r_p_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
// 640x480@60 Hz VGA timing generator for the frogger display path.
//
// Stage 0: x, y and video_on come straight from the registered counters.
// Stage 1: hsync, vsync and rgb are registered on each pixel tick from the
//          stage-0 values, so they lag x/y by one tick and stay mutually
//          aligned at the connector.
//
// Interface timing: there is no handshake. The renderer samples x/y
// combinationally and must present rgb_in for that pixel before the next
// pixel tick, which leaves CLK_DIV-1 clocks of slack.
//
// Optional build macro VGA_TEST_PATTERN_EN adds the pattern_sel input; with
// pattern_sel high the stage-1 colour shows eight 80-pixel colour bars
// instead of rgb_in (blanking still applies).
// ---------------------------------------------------------------------------
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEFAULT,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RGB_W-1:0] rgb_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             pattern_sel,
`endif
    output logic             p_tick,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb
);

    // Boundary constants for this instance, all unsigned 10-bit.
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // Stage-0 counters.
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;

    // Stage-1 outputs.
    logic             r_hsync;
    logic             r_vsync;
    rgb_t             r_rgb;

    // Combinational stage-0 terms.
    logic             w_p_tick;
    logic             w_x_wrap;
    logic             w_y_wrap;
    logic             w_video_on;
    logic             w_hs_active;
    logic             w_vs_active;
    rgb_t             w_src_rgb;
    rgb_t             w_blanked_rgb;

    // Pixel-rate enable.
    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (w_p_tick)
    );

    assign w_x_wrap = (r_x == H_LAST);
    assign w_y_wrap = (r_y == V_LAST);

    // Horizontal counter: one step per pixel tick, wraps at end of line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= '0;
        end else if (w_p_tick) begin
            if (w_x_wrap) begin
                r_x <= '0;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    // Vertical counter: steps on the same edge that x wraps, wraps at end of frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y <= '0;
        end else if (w_p_tick && w_x_wrap) begin
            if (w_y_wrap) begin
                r_y <= '0;
            end else begin
                r_y <= r_y + 1'b1;
            end
        end
    end

    assign w_video_on  = (r_x < H_VIS) && (r_y < V_VIS);
    assign w_hs_active = (r_x >= HS_FIRST) && (r_x <= HS_LAST);
    assign w_vs_active = (r_y >= VS_FIRST) && (r_y <= VS_LAST);

`ifdef VGA_TEST_PATTERN_EN
    // Bar index is x/80; only meaningful inside the visible area, where it is 0..7.
    logic [2:0] w_bar_idx;
    assign w_bar_idx = 3'(r_x / CNT_W'(BAR_W));
    assign w_src_rgb = pattern_sel ? bar_colour(w_bar_idx) : rgb_in;
`else
    assign w_src_rgb = rgb_in;
`endif

    assign w_blanked_rgb = w_video_on ? w_src_rgb : '0;

    // Stage-1 sync and colour, captured together on each pixel tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= '0;
        end else if (w_p_tick) begin
            r_hsync <= ~w_hs_active;
            r_vsync <= ~w_vs_active;
            r_rgb   <= w_blanked_rgb;
        end
    end

    assign p_tick   = w_p_tick;
    assign x        = r_x;
    assign y        = r_y;
    assign video_on = w_video_on;
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign rgb      = r_rgb;

endmodule
